// File: rtl/ccp_wr_trk_pkg.sv
// Shared types and error-bit encoding for the CCP write-transaction tracker.
package ccp_wr_trk_pkg;

  localparam int unsigned N_ERR = 6;

  localparam int unsigned ERR_OVERFLOW    = 0;
  localparam int unsigned ERR_NO_TXN      = 1;
  localparam int unsigned ERR_LAST        = 2;
  localparam int unsigned ERR_BEAT_REPEAT = 3;
  localparam int unsigned ERR_BYTE_EN     = 4;
  localparam int unsigned ERR_HOLD        = 5;

  // Descriptor burst length is stored at a fixed maximum width; ports use the low bits.
  localparam int unsigned MaxBurstLenW = 8;

  typedef struct packed {
    logic                    full;
    logic [MaxBurstLenW-1:0] burst_len;
    logic                    bypass;
  } wr_desc_t;

  function automatic wr_desc_t make_desc(input logic                    full,
                                         input logic [MaxBurstLenW-1:0] burst_len,
                                         input logic                    bypass);
    wr_desc_t d;
    d.full      = full;
    d.burst_len = burst_len;
    d.bypass    = bypass;
    return d;
  endfunction

endpackage

// File: rtl/ccp_wr_txn_tracker_if.sv
// Op-push and per-port write-data bundle observed by the tracker, plus its status outputs.
interface ccp_wr_txn_tracker_if #(
  parameter int unsigned N_WR_PORTS  = 2,
  parameter int unsigned BURST_LEN_W = 2,
  parameter int unsigned DATA_W      = 128
) ();

  localparam int unsigned PORT_W    = (N_WR_PORTS > 1) ? $clog2(N_WR_PORTS) : 1;
  localparam int unsigned BYTE_EN_W = DATA_W / 8;
  localparam int unsigned ErrW      = N_WR_PORTS * ccp_wr_trk_pkg::N_ERR;

  logic                              op_push;
  logic [PORT_W-1:0]                 op_port_sel;
  logic                              op_full;
  logic [BURST_LEN_W-1:0]            op_burst_len;
  logic                              op_bypass;
  logic [N_WR_PORTS-1:0]             wr_valid;
  logic [N_WR_PORTS-1:0]             wr_ready;
  logic [N_WR_PORTS-1:0]             wr_last;
  logic [N_WR_PORTS*BURST_LEN_W-1:0] wr_beat_num;
  logic [N_WR_PORTS*BYTE_EN_W-1:0]   wr_byte_en;
  logic [N_WR_PORTS*DATA_W-1:0]      wr_data;
  logic [N_WR_PORTS-1:0]             q_empty;
  logic [N_WR_PORTS-1:0]             q_full;
  logic [N_WR_PORTS-1:0]             exp_last;
  logic [N_WR_PORTS-1:0]             exp_full_be;
  logic [N_WR_PORTS-1:0]             head_bypass;
  logic [ErrW-1:0]                   err;
  logic                              err_any;

  modport master (
    output op_push, op_port_sel, op_full, op_burst_len, op_bypass,
    output wr_valid, wr_ready, wr_last, wr_beat_num, wr_byte_en, wr_data,
    input  q_empty, q_full, exp_last, exp_full_be, head_bypass, err, err_any
  );

  modport slave (
    input  op_push, op_port_sel, op_full, op_burst_len, op_bypass,
    input  wr_valid, wr_ready, wr_last, wr_beat_num, wr_byte_en, wr_data,
    output q_empty, q_full, exp_last, exp_full_be, head_bypass, err, err_any
  );

endinterface

// File: rtl/ccp_wr_trk_port.sv
// One write port: descriptor FIFO with fall-through head, beat tracking, stall capture and
// sticky protocol-error flags.
module ccp_wr_trk_port
  import ccp_wr_trk_pkg::*;
#(
  parameter int unsigned Q_DEPTH     = 4,
  parameter int unsigned BURST_LEN_W = 2,
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned BYTE_EN_W   = DATA_W / 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  wr_desc_t               desc_i,
  input  logic                   wr_valid_i,
  input  logic                   wr_ready_i,
  input  logic                   wr_last_i,
  input  logic [BURST_LEN_W-1:0] wr_beat_num_i,
  input  logic [BYTE_EN_W-1:0]   wr_byte_en_i,
  input  logic [DATA_W-1:0]      wr_data_i,
  output logic                   q_empty_o,
  output logic                   q_full_o,
  output logic                   exp_last_o,
  output logic                   exp_full_be_o,
  output logic                   head_bypass_o,
  output logic [N_ERR-1:0]       err_o
);

  localparam int unsigned PtrW     = $clog2(Q_DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam int unsigned BurstLen = 2 ** BURST_LEN_W;

  wr_desc_t               mem_q [Q_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        cnt_q;
  logic [BURST_LEN_W-1:0] beat_cnt_q;
  logic [BurstLen-1:0]    bitmap_q;
  logic                   stall_q;
  logic [DATA_W-1:0]      cap_data_q;
  logic [BYTE_EN_W-1:0]   cap_be_q;
  logic [BURST_LEN_W-1:0] cap_num_q;
  logic                   cap_last_q;
  logic [N_ERR-1:0]       err_q, err_d;

  wr_desc_t head;
  logic     empty, full, head_avail, hs, pop, push_acc, overflow, hold_diff;

  always_comb begin
    empty      = (cnt_q == '0);
    full       = (cnt_q == CntW'(Q_DEPTH));
    head_avail = ~empty | push_i;
    // Empty FIFO with a push this cycle exposes the incoming descriptor directly.
    head       = empty ? desc_i : mem_q[rd_ptr_q];
    hs         = wr_valid_i & wr_ready_i;
    pop        = hs & wr_last_i & head_avail;
    push_acc   = push_i & (~full | pop);
    overflow   = push_i & full & ~pop;

    q_empty_o     = empty;
    q_full_o      = full;
    exp_last_o    = head_avail & (MaxBurstLenW'(beat_cnt_q) == head.burst_len);
    exp_full_be_o = head_avail & head.full;
    head_bypass_o = head_avail & head.bypass;

    hold_diff = (wr_data_i != cap_data_q) | (wr_byte_en_i != cap_be_q) |
                (wr_beat_num_i != cap_num_q) | (wr_last_i != cap_last_q);

    err_d                  = err_q;
    err_d[ERR_OVERFLOW]    = err_q[ERR_OVERFLOW] | overflow;
    err_d[ERR_NO_TXN]      = err_q[ERR_NO_TXN] | (wr_valid_i & ~head_avail);
    err_d[ERR_LAST]        = err_q[ERR_LAST] |
                             (wr_valid_i & head_avail & (wr_last_i != exp_last_o));
    err_d[ERR_BEAT_REPEAT] = err_q[ERR_BEAT_REPEAT] | (hs & bitmap_q[wr_beat_num_i]);
    err_d[ERR_BYTE_EN]     = err_q[ERR_BYTE_EN] |
                             (wr_valid_i & exp_full_be_o & ~&wr_byte_en_i);
    err_d[ERR_HOLD]        = err_q[ERR_HOLD] | (stall_q & (~wr_valid_i | hold_diff));
  end

  assign err_o = err_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < Q_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      beat_cnt_q <= '0;
      bitmap_q   <= '0;
      stall_q    <= 1'b0;
      cap_data_q <= '0;
      cap_be_q   <= '0;
      cap_num_q  <= '0;
      cap_last_q <= 1'b0;
      err_q      <= '0;
    end else begin
      // A fall-through push+pop writes and consumes the same slot, leaving the count at zero.
      if (push_acc) begin
        mem_q[wr_ptr_q] <= desc_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CntW'(push_acc) - CntW'(pop);

      if (pop) begin
        beat_cnt_q <= '0;
        bitmap_q   <= '0;
      end else if (hs) begin
        beat_cnt_q              <= beat_cnt_q + 1'b1;
        bitmap_q[wr_beat_num_i] <= 1'b1;
      end

      stall_q <= wr_valid_i & ~wr_ready_i;
      if (wr_valid_i) begin
        cap_data_q <= wr_data_i;
        cap_be_q   <= wr_byte_en_i;
        cap_num_q  <= wr_beat_num_i;
        cap_last_q <= wr_last_i;
      end

      err_q <= err_d;
    end
  end

endmodule

// File: rtl/ccp_wr_txn_tracker.sv
// Multi-port CCP write-transaction tracker: decodes op pushes to per-port trackers and
// aggregates their sticky error flags.
module ccp_wr_txn_tracker
  import ccp_wr_trk_pkg::*;
#(
  parameter int unsigned N_WR_PORTS  = 2,
  parameter int unsigned Q_DEPTH     = 4,
  parameter int unsigned BURST_LEN_W = 2,
  parameter int unsigned DATA_W      = 128
) (
  input logic                 clk_i,
  input logic                 reset_i,
  ccp_wr_txn_tracker_if.slave bus
);

  localparam int unsigned PORT_W    = (N_WR_PORTS > 1) ? $clog2(N_WR_PORTS) : 1;
  localparam int unsigned BYTE_EN_W = DATA_W / 8;

  wr_desc_t                      op_desc;
  logic [N_WR_PORTS-1:0]         push;
  logic [N_WR_PORTS-1:0]         q_empty, q_full, exp_last, exp_full_be, head_bypass;
  logic [N_WR_PORTS*N_ERR-1:0]   err;
  logic                          err_any_q;

  assign op_desc = make_desc(bus.op_full, MaxBurstLenW'(bus.op_burst_len), bus.op_bypass);

  for (genvar p = 0; p < N_WR_PORTS; p++) begin : g_port
    assign push[p] = bus.op_push & (bus.op_port_sel == PORT_W'(p));

    ccp_wr_trk_port #(
      .Q_DEPTH    (Q_DEPTH),
      .BURST_LEN_W(BURST_LEN_W),
      .DATA_W     (DATA_W),
      .BYTE_EN_W  (BYTE_EN_W)
    ) u_port (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .push_i       (push[p]),
      .desc_i       (op_desc),
      .wr_valid_i   (bus.wr_valid[p]),
      .wr_ready_i   (bus.wr_ready[p]),
      .wr_last_i    (bus.wr_last[p]),
      .wr_beat_num_i(bus.wr_beat_num[p*BURST_LEN_W +: BURST_LEN_W]),
      .wr_byte_en_i (bus.wr_byte_en[p*BYTE_EN_W +: BYTE_EN_W]),
      .wr_data_i    (bus.wr_data[p*DATA_W +: DATA_W]),
      .q_empty_o    (q_empty[p]),
      .q_full_o     (q_full[p]),
      .exp_last_o   (exp_last[p]),
      .exp_full_be_o(exp_full_be[p]),
      .head_bypass_o(head_bypass[p]),
      .err_o        (err[p*N_ERR +: N_ERR])
    );
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) err_any_q <= 1'b0;
    else         err_any_q <= |err;
  end

  assign bus.q_empty     = q_empty;
  assign bus.q_full      = q_full;
  assign bus.exp_last    = exp_last;
  assign bus.exp_full_be = exp_full_be;
  assign bus.head_bypass = head_bypass;
  assign bus.err         = err;
  assign bus.err_any     = err_any_q;

endmodule

// File: tb/tb_ccp_wr_txn_tracker.sv
// Directed bench for ccp_wr_txn_tracker with hand-computed expectations.
module tb_ccp_wr_txn_tracker;

  localparam int unsigned NP  = 2;
  localparam int unsigned QD  = 4;
  localparam int unsigned BLW = 2;
  localparam int unsigned DW  = 128;
  localparam int unsigned BEW = DW / 8;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  ccp_wr_txn_tracker_if #(.N_WR_PORTS(NP), .BURST_LEN_W(BLW), .DATA_W(DW)) bus ();

  ccp_wr_txn_tracker #(
    .N_WR_PORTS (NP),
    .Q_DEPTH    (QD),
    .BURST_LEN_W(BLW),
    .DATA_W     (DW)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic en, input logic sel, input logic full,
                          input logic [BLW-1:0] len, input logic byp);
    bus.op_push      = en;
    bus.op_port_sel  = sel;
    bus.op_full      = full;
    bus.op_burst_len = len;
    bus.op_bypass    = byp;
  endtask

  task automatic drive(input int p, input logic v, input logic r, input logic l,
                       input logic [BLW-1:0] num, input logic [BEW-1:0] be,
                       input logic [DW-1:0] d);
    bus.wr_valid[p]              = v;
    bus.wr_ready[p]              = r;
    bus.wr_last[p]               = l;
    bus.wr_beat_num[p*BLW +: BLW] = num;
    bus.wr_byte_en[p*BEW +: BEW] = be;
    bus.wr_data[p*DW +: DW]      = d;
  endtask

  task automatic idle();
    set_push(1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int p = 0; p < NP; p++) drive(p, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_q_empty", bus.q_empty, 2'b11);
    check("rst_q_full", bus.q_full, 2'b00);
    check("rst_err", bus.err, 12'h000);
    check("rst_err_any", bus.err_any, 1'b0);
    check("rst_exp_last", bus.exp_last, 2'b00);

    // Full 4-beat burst on port 0.
    set_push(1'b1, 1'b0, 1'b1, 2'd3, 1'b0);
    #1;
    check("t1_ft_full_be", bus.exp_full_be, 2'b01);
    check("t1_ft_exp_last", bus.exp_last, 2'b00);
    tick();
    set_push(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("t1_q_empty_after_push", bus.q_empty, 2'b10);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 1'b1, (i == 3), BLW'(i), '1, DW'(i + 32'h100));
      #1;
      check($sformatf("t1_exp_last_beat%0d", i), bus.exp_last[0], (i == 3));
      tick();
    end
    idle();
    check("t1_q_empty_after_pop", bus.q_empty, 2'b11);
    check("t1_err", bus.err, 12'h000);

    // Overflow on port 1.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_push(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
      tick();
    end
    check("t2_q_full_after3", bus.q_full, 2'b00);
    tick();
    check("t2_q_full_after4", bus.q_full, 2'b10);
    check("t2_err_before_ovf", bus.err, 12'h000);
    tick();
    set_push(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("t2_err_ovf", bus.err, 12'h040);
    check("t2_err_any_lag", bus.err_any, 1'b0);
    tick();
    check("t2_err_any", bus.err_any, 1'b1);
    check("t2_q_full_kept", bus.q_full, 2'b10);

    // Stall hold: unchanged payload is fine, changed payload flags ERR_HOLD.
    do_reset();
    set_push(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    set_push(1'b0, 1'b0, 1'b0, '0, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b1, 2'd0, '1, 128'hAAAA);
    tick();
    tick();
    check("t3_hold_same", bus.err, 12'h000);
    drive(0, 1'b1, 1'b0, 1'b1, 2'd0, '1, 128'hBBBB);
    tick();
    check("t3_hold_changed", bus.err, 12'h020);
    drive(0, 1'b1, 1'b1, 1'b1, 2'd0, '1, 128'hBBBB);
    tick();
    idle();
    check("t3_err_final", bus.err, 12'h020);
    check("t3_q_empty", bus.q_empty, 2'b11);

    // Fall-through single-beat bypass on port 1.
    do_reset();
    set_push(1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
    drive(1, 1'b1, 1'b1, 1'b1, 2'd0, 16'h0000, 128'h55);
    #1;
    check("t4_head_bypass", bus.head_bypass, 2'b10);
    check("t4_exp_last", bus.exp_last, 2'b10);
    tick();
    idle();
    check("t4_q_empty", bus.q_empty, 2'b11);
    check("t4_err", bus.err, 12'h000);

    // Repeated beat number plus early last.
    do_reset();
    set_push(1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
    tick();
    set_push(1'b0, 1'b0, 1'b0, '0, 1'b0);
    drive(0, 1'b1, 1'b1, 1'b0, 2'd0, '1, 128'h1);
    tick();
    drive(0, 1'b1, 1'b1, 1'b0, 2'd1, '1, 128'h2);
    tick();
    check("t5_err_before", bus.err, 12'h000);
    drive(0, 1'b1, 1'b1, 1'b1, 2'd1, '1, 128'h3);
    #1;
    check("t5_exp_last_beat2", bus.exp_last, 2'b00);
    tick();
    idle();
    check("t5_err_repeat_last", bus.err, 12'h00C);
    check("t5_q_empty", bus.q_empty, 2'b11);
    tick();
    check("t5_err_any", bus.err_any, 1'b1);

    // Reset mid-burst, then a clean 2-beat burst.
    do_reset();
    set_push(1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
    tick();
    set_push(1'b0, 1'b0, 1'b0, '0, 1'b0);
    drive(0, 1'b1, 1'b1, 1'b0, 2'd0, '1, 128'h10);
    tick();
    drive(0, 1'b1, 1'b1, 1'b0, 2'd1, '1, 128'h11);
    tick();
    drive(0, 1'b1, 1'b0, 1'b0, 2'd2, '1, 128'h12);
    reset = 1'b1;
    #1;
    check("t6_rst_q_empty", bus.q_empty, 2'b11);
    check("t6_rst_err", bus.err, 12'h000);
    tick();
    idle();
    reset = 1'b0;
    #1;
    check("t6_post_rst_err", bus.err, 12'h000);
    set_push(1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
    tick();
    set_push(1'b0, 1'b0, 1'b0, '0, 1'b0);
    drive(0, 1'b1, 1'b1, 1'b0, 2'd0, '1, 128'h20);
    #1;
    check("t6_exp_last_b0", bus.exp_last, 2'b00);
    tick();
    drive(0, 1'b1, 1'b1, 1'b1, 2'd1, '1, 128'h21);
    #1;
    check("t6_exp_last_b1", bus.exp_last, 2'b01);
    tick();
    idle();
    check("t6_err", bus.err, 12'h000);
    check("t6_q_empty", bus.q_empty, 2'b11);

    // Independent errors: partial byte-enable on port 0, no transaction on port 1.
    do_reset();
    set_push(1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    tick();
    set_push(1'b0, 1'b0, 1'b0, '0, 1'b0);
    drive(0, 1'b1, 1'b1, 1'b1, 2'd0, 16'h00FF, 128'h30);
    drive(1, 1'b1, 1'b1, 1'b0, 2'd0, '1, 128'h31);
    #1;
    check("t7_exp_full_be", bus.exp_full_be, 2'b01);
    tick();
    idle();
    check("t7_err", bus.err, 12'h090);
    check("t7_q_empty", bus.q_empty, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
